// File: rtl/serial_word_loader.sv
// serial_word_loader: framed MSB-first serial-to-parallel loader with a one-cycle write strobe
module serial_word_loader #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Abort,
  input  logic         serIn,
  input  logic         serValid,
  output logic [N-1:0] nBitOut,
  output logic         WE,
  output logic         Busy
);
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
  state_t        state;
  logic [N-1:0]  sr;
  logic [CW-1:0] cnt;
  logic [N-1:0]  nxt;
  assign nxt = {sr[N-2:0], serIn};
  always_ff @(posedge clk) begin
    if (Reset) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      nBitOut <= '0;
      WE      <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          state <= SHIFT;
          sr    <= '0;
          cnt   <= '0;
          Busy  <= 1'b1;
        end
        SHIFT: if (Abort) begin
          state <= IDLE;
          cnt   <= '0;
          Busy  <= 1'b0;
        end else if (serValid) begin
          sr <= nxt;
          if (cnt == CW'(N - 1)) begin
            nBitOut <= nxt;
            state   <= LOAD;
            WE      <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        LOAD: begin
          state <= IDLE;
          WE    <= 1'b0;
          Busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          WE    <= 1'b0;
          Busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_word_loader.sv
// tb_serial_word_loader: directed tests for serial_word_loader with a downstream register model
module tb_serial_word_loader;
  logic        clk = 1'b0;
  logic        Reset = 1'b0, Start = 1'b0, Abort = 1'b0, serIn = 1'b0, serValid = 1'b0;
  logic [15:0] nBitOut;
  logic        WE, Busy;
  logic [15:0] hold = 16'h0;
  int          cyc = 0, we_cnt = 0, we_cyc = -1;
  int          checks = 0, errors = 0;

  serial_word_loader #(.N(16)) dut (
    .clk(clk), .Reset(Reset), .Start(Start), .Abort(Abort), .serIn(serIn),
    .serValid(serValid), .nBitOut(nBitOut), .WE(WE), .Busy(Busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (WE === 1'b1) hold <= nBitOut;
  always @(negedge clk) if (WE === 1'b1) begin
    we_cnt++;
    we_cyc = cyc;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // feeds nb MSB-first bits of w, with sl stall cycles after bit numbers s1 and s2;
  // stable reports whether nBitOut held its entry value until the word completed
  task automatic drive_bits(input logic [15:0] w, input int nb, input int s1, input int s2,
                            input int sl, output bit stable);
    logic [15:0] v0;
    v0 = nBitOut;
    stable = 1'b1;
    for (int i = 0; i < nb; i++) begin
      serValid = 1'b1;
      serIn = w[15-i];
      tick();
      if (i != 15 && nBitOut !== v0) stable = 1'b0;
      if (i + 1 == s1 || i + 1 == s2) begin
        for (int j = 0; j < sl; j++) begin
          serValid = 1'b0;
          serIn = 1'($urandom);
          tick();
          if (nBitOut !== v0) stable = 1'b0;
        end
      end
    end
    serValid = 1'b0;
  endtask

  task automatic test_reset;
    int base;
    for (int i = 0; i < 2; i++) begin
      Reset = 1'b1; Start = 1'($urandom); Abort = 1'($urandom);
      serIn = 1'($urandom); serValid = 1'($urandom);
      tick();
    end
    Reset = 1'b0; Start = 1'b0; Abort = 1'b0; serValid = 1'b0;
    checks++; if (nBitOut !== 16'h0) begin errors++; $display("FAIL reset_out got %h exp 0000", nBitOut); end
    checks++; if (WE !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", WE); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", Busy); end
    base = we_cnt;
    repeat (3) tick();
    checks++; if (we_cnt !== base) begin errors++; $display("FAIL reset_no_we got %0d exp %0d", we_cnt, base); end
  endtask

  task automatic test_basic;
    int cs, base;
    bit st;
    base = we_cnt; cs = cyc;
    Start = 1'b1; tick(); Start = 1'b0;
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", Busy); end
    drive_bits(16'hA5C3, 16, 0, 0, 0, st);
    checks++; if (WE !== 1'b1) begin errors++; $display("FAIL basic_we got %b exp 1", WE); end
    checks++; if (nBitOut !== 16'hA5C3) begin errors++; $display("FAIL basic_out got %h exp a5c3", nBitOut); end
    tick();
    checks++; if (we_cyc !== cs + 17) begin errors++; $display("FAIL basic_we_cycle got %0d exp %0d", we_cyc - cs, 17); end
    checks++; if (we_cnt !== base + 1) begin errors++; $display("FAIL basic_we_count got %0d exp 1", we_cnt - base); end
    checks++; if (WE !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL basic_idle got we=%b busy=%b exp 0 0", WE, Busy); end
    checks++; if (hold !== 16'hA5C3) begin errors++; $display("FAIL basic_hold got %h exp a5c3", hold); end
  endtask

  task automatic test_stalls;
    int cs, base;
    bit st;
    base = we_cnt; cs = cyc;
    Start = 1'b1; tick(); Start = 1'b0;
    drive_bits(16'h1234, 16, 4, 12, 3, st);
    checks++; if (!st) begin errors++; $display("FAIL stall_hold got changed exp a5c3 held"); end
    checks++; if (WE !== 1'b1 || nBitOut !== 16'h1234) begin errors++; $display("FAIL stall_load got we=%b out=%h exp 1 1234", WE, nBitOut); end
    tick();
    checks++; if (we_cyc !== cs + 23 || we_cnt !== base + 1) begin errors++; $display("FAIL stall_we_cycle got %0d/%0d exp 23/1", we_cyc - cs, we_cnt - base); end
  endtask

  task automatic test_abort;
    int base;
    bit st;
    base = we_cnt;
    Start = 1'b1; tick(); Start = 1'b0;
    drive_bits(16'hDEAD, 7, 0, 0, 0, st);
    Abort = 1'b1; tick(); Abort = 1'b0;
    checks++; if (Busy !== 1'b0 || nBitOut !== 16'h1234) begin errors++; $display("FAIL abort7 got busy=%b out=%h exp 0 1234", Busy, nBitOut); end
    repeat (3) tick();
    Start = 1'b1; tick(); Start = 1'b0;
    drive_bits(16'hBEEF, 15, 0, 0, 0, st);
    serValid = 1'b1; serIn = 1'b1; Abort = 1'b1; tick();
    serValid = 1'b0; Abort = 1'b0;
    checks++; if (Busy !== 1'b0 || WE !== 1'b0 || nBitOut !== 16'h1234) begin errors++; $display("FAIL abort_last got busy=%b we=%b out=%h exp 0 0 1234", Busy, WE, nBitOut); end
    repeat (3) tick();
    checks++; if (we_cnt !== base) begin errors++; $display("FAIL abort_no_we got %0d exp 0", we_cnt - base); end
    Start = 1'b1; tick(); Start = 1'b0;
    drive_bits(16'hFFFF, 16, 0, 0, 0, st);
    tick();
    checks++; if (nBitOut !== 16'hFFFF || we_cnt !== base + 1 || hold !== 16'hFFFF) begin errors++; $display("FAIL abort_next got out=%h we=%0d hold=%h exp ffff 1 ffff", nBitOut, we_cnt - base, hold); end
  endtask

  task automatic test_ignored;
    int base, cs;
    bit st;
    base = we_cnt;
    Start = 1'b1; tick();
    drive_bits(16'h5A5A, 16, 0, 0, 0, st);
    tick();
    checks++; if (we_cnt !== base + 1 || Busy !== 1'b0) begin errors++; $display("FAIL start_held got we=%0d busy=%b exp 1 0", we_cnt - base, Busy); end
    tick(); Start = 1'b0;
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL start_restart got busy=%b exp 1", Busy); end
    drive_bits(16'h3C3C, 16, 0, 0, 0, st);
    Start = 1'b1; tick(); Start = 1'b0;
    tick();
    checks++; if (nBitOut !== 16'h3C3C || Busy !== 1'b0 || we_cnt !== base + 2) begin errors++; $display("FAIL start_in_load got out=%h busy=%b we=%0d exp 3c3c 0 2", nBitOut, Busy, we_cnt - base); end
    serValid = 1'b1; serIn = 1'b1;
    repeat (4) tick();
    checks++; if (Busy !== 1'b0 || we_cnt !== base + 2) begin errors++; $display("FAIL valid_idle got busy=%b we=%0d exp 0 2", Busy, we_cnt - base); end
    cs = cyc; Start = 1'b1; tick(); Start = 1'b0;
    drive_bits(16'h6D91, 16, 0, 0, 0, st);
    tick();
    checks++; if (we_cyc !== cs + 17 || hold !== 16'h6D91) begin errors++; $display("FAIL valid_at_start got cyc=%0d hold=%h exp 17 6d91", we_cyc - cs, hold); end
  endtask

  task automatic test_mid_reset;
    int base;
    bit st;
    base = we_cnt;
    Start = 1'b1; tick(); Start = 1'b0;
    drive_bits(16'h0F0F, 10, 0, 0, 0, st);
    Reset = 1'b1; tick(); Reset = 1'b0;
    checks++; if (nBitOut !== 16'h0 || Busy !== 1'b0 || WE !== 1'b0) begin errors++; $display("FAIL midreset got out=%h busy=%b we=%b exp 0000 0 0", nBitOut, Busy, WE); end
    repeat (3) tick();
    checks++; if (we_cnt !== base) begin errors++; $display("FAIL midreset_no_we got %0d exp 0", we_cnt - base); end
    Start = 1'b1; tick(); Start = 1'b0;
    drive_bits(16'h8001, 16, 0, 0, 0, st);
    tick();
    checks++; if (nBitOut !== 16'h8001 || we_cnt !== base + 1) begin errors++; $display("FAIL midreset_next got out=%h we=%0d exp 8001 1", nBitOut, we_cnt - base); end
  endtask

  task automatic test_back_to_back;
    int cs, first;
    bit st;
    cs = cyc;
    Start = 1'b1; tick(); Start = 1'b0;
    drive_bits(16'h1111, 16, 0, 0, 0, st);
    tick();
    first = we_cyc;
    Start = 1'b1; tick(); Start = 1'b0;
    drive_bits(16'h2222, 16, 0, 0, 0, st);
    tick();
    checks++; if (first !== cs + 17 || we_cyc !== cs + 35) begin errors++; $display("FAIL b2b_period got %0d/%0d exp 17/35", first - cs, we_cyc - cs); end
    checks++; if (hold !== 16'h2222) begin errors++; $display("FAIL b2b_hold got %h exp 2222", hold); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stalls();
    test_abort();
    test_ignored();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_word_loader.md
# serial_word_loader

Serial-to-parallel front end for the 16-bit holding register. It accepts a framed MSB-first bit stream, assembles an N-bit word, and presents it on `nBitOut`. When the word is complete it pulses `WE` for exactly one cycle, so the downstream register captures the word on the following clock edge. Port names match the register's `nBitIn`/`WE` so the two blocks connect point-to-point.

## Interface
- `N`, default 16: word width; must be ≥ 2.
- `clk`  in  1  rising-edge clock shared with the downstream register.
- `Reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  begin a new frame; sampled only in IDLE.
- `Abort`  in  1  cancel the frame in progress; sampled only in SHIFT.
- `serIn`  in  1  serial data bit, MSB first.
- `serValid`  in  1  `serIn` is valid this cycle; sampled only in SHIFT.
- `nBitOut`  out  N  last completed word; drives the register's `nBitIn`.
- `WE`  out  1  one-cycle write strobe; drives the register's `WE`.
- `Busy`  out  1  high in SHIFT and LOAD.

## Operation
- One clock, `clk`. `Reset` is synchronous and active-high.
- Internal state:
  - N-bit shift register `sr`.
  - Bit counter `cnt`, width ceil(log2(N)).
  - N-bit output register driving `nBitOut`.
  - 2-bit state: IDLE, SHIFT, LOAD.
- On a reset edge:
  - state goes to IDLE.
  - `sr`, `cnt` and `nBitOut` are cleared to 0.
  - `WE` and `Busy` are 0.
  - Reset takes priority over every other input, including in mid-frame. An interrupted frame produces no `WE`.
- IDLE:
  - `Busy` = 0, `WE` = 0.
  - `Start` = 1 moves to SHIFT and clears `sr` and `cnt`.
  - `serValid` is ignored, including in the cycle where `Start` is high.
- SHIFT:
  - `Busy` = 1.
  - If `Abort` = 1: go to IDLE, clear `cnt`, leave `nBitOut` unchanged. Abort wins over a simultaneous valid bit, even the last one.
  - Else if `serValid` = 1: `sr` <= {`sr`[N-2:0], `serIn`}.
    - If `cnt` = N-1: `nBitOut` <= {`sr`[N-2:0], `serIn`} and go to LOAD.
    - Otherwise `cnt` <= `cnt` + 1.
  - `serValid` = 0 means stall: hold all state, with no limit on stall length.
  - `Start` is ignored.
- LOAD:
  - `WE` = 1 and `Busy` = 1 for exactly one cycle, then go to IDLE unconditionally.
  - `Start`, `Abort`, `serValid` and `serIn` are ignored.
- `nBitOut` changes only on the SHIFT→LOAD edge or on reset. It is stable throughout IDLE and SHIFT, so the downstream register always holds a coherent word.
- `WE` is a registered state decode (state == LOAD) with no combinational path from any input.
- No wrap-around: `cnt` never exceeds N-1.

## Timing
- Cycle k: `Start` = 1 in IDLE. Cycle k+1: state = SHIFT, `Busy` = 1.
- The first bit is accepted no earlier than cycle k+1.
- With `serValid` held high from k+1:
  - The Nth bit is sampled in cycle k+N.
  - `WE` = 1 and the new `nBitOut` are visible in cycle k+N+1.
  - The downstream register holds the word after the edge ending cycle k+N+1.
- Each stall cycle adds one cycle of latency.
- Minimum frame period is N+2 cycles: Start, N bits, LOAD.
- `Start` may be asserted in the first IDLE cycle after LOAD.
- A `Start` asserted during LOAD is dropped, not queued.
- Abort latency: `Busy` drops the cycle after `Abort` is sampled.

## Test plan
- **Reset:** assert `Reset` for 2 cycles with random inputs → `nBitOut` = 0x0000, `WE` = 0, `Busy` = 0. No `WE` appears until a full frame completes.
- **Basic frame (N=16):** `Start`, then 16 contiguous valid bits of 0xA5C3, MSB first → `WE` high for exactly 1 cycle, 17 cycles after `Start`. `nBitOut` = 0xA5C3 in that cycle; the downstream register reads 0xA5C3 afterwards.
- **Stalls:** frame 0x1234 with `serValid` low for 3 cycles after bits 4 and 12 → `WE` 23 cycles after `Start`, `nBitOut` = 0x1234. `nBitOut` keeps its previous value (0xA5C3) until the LOAD cycle.
- **Abort:**
  - `Abort` after 7 bits → IDLE next cycle, no `WE`, `nBitOut` still 0x1234.
  - `Abort` coincident with the 16th valid bit → no `WE`, `nBitOut` unchanged.
  - A following full frame 0xFFFF loads correctly.
- **Ignored inputs:**
  - `Start` held high through an entire frame → exactly one `WE`, then a new frame starts the cycle after LOAD.
  - `serValid` = 1 in IDLE → no shift, `Busy` stays 0.
- **Mid-frame reset:** `Reset` after 10 bits of 0x0F0F → `nBitOut` = 0, no `WE`. A following frame 0x8001 → `nBitOut` = 0x8001.
